// File: rtl/cache_mem_port.sv
// AXI4-Lite memory port for the external-memory cache: runs the line write-back, the line reload, or both in that order.
// Optional watchdog: define CACHE_MEM_PORT_TIMEOUT_EN to abort stalled AXI transfers after TIMEOUT_CYCLES.
module cache_mem_port #(
    parameter int BITS           = 32,
    parameter int ADDRESS_BITS   = 28,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_evict,
    input  logic                    req_reload,
    input  logic [ADDRESS_BITS-1:0] req_evict_addr,
    input  logic [ADDRESS_BITS-1:0] req_addr,
    input  logic [BITS-1:0]         req_wdata,
    input  logic [3:0]              req_wstrb,
    output logic                    rsp_valid,
    output logic [BITS-1:0]         rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDRESS_BITS+1:0] axi_ext_araddr,
    output logic                    axi_ext_arvalid,
    input  logic                    axi_ext_arready,
    input  logic                    axi_ext_rvalid,
    output logic                    axi_ext_rready,
    input  logic [BITS-1:0]         axi_ext_rdata,
    input  logic [1:0]              axi_ext_rresp,
    output logic [ADDRESS_BITS+1:0] axi_ext_awaddr,
    output logic                    axi_ext_awvalid,
    input  logic                    axi_ext_awready,
    output logic                    axi_ext_wvalid,
    input  logic                    axi_ext_wready,
    output logic [BITS-1:0]         axi_ext_wdata,
    output logic [3:0]              axi_ext_wstrb,
    input  logic                    axi_ext_bvalid,
    output logic                    axi_ext_bready,
    input  logic [1:0]              axi_ext_bresp
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WB_REQ  = 3'd1;
    localparam logic [2:0] S_WB_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]              state;
    logic [2:0]              state_next;
    logic                    evict_q;
    logic                    reload_q;
    logic [ADDRESS_BITS-1:0] evict_addr_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    err_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    timeout_hit;

    // NOTE: channel valids/readies decode straight from state flops, so a reset or abort clears them on the very next cycle.
    assign axi_ext_awvalid = (state == S_WB_REQ) && !aw_done;
    assign axi_ext_wvalid  = (state == S_WB_REQ) && !w_done;
    assign axi_ext_bready  = (state == S_WB_RESP);
    assign axi_ext_arvalid = (state == S_RD_ADDR);
    assign axi_ext_rready  = (state == S_RD_DATA);
    assign axi_ext_awaddr  = {evict_addr_q, 2'b00};
    assign axi_ext_araddr  = {addr_q, 2'b00};
    assign rsp_valid       = (state == S_DONE);
    assign rsp_err         = (state == S_DONE) && err_q;

    assign aw_hs = axi_ext_awvalid && axi_ext_awready;
    assign w_hs  = axi_ext_wvalid  && axi_ext_wready;
    assign b_hs  = axi_ext_bready  && axi_ext_bvalid;
    assign ar_hs = axi_ext_arvalid && axi_ext_arready;
    assign r_hs  = axi_ext_rready  && axi_ext_rvalid;

`ifdef CACHE_MEM_PORT_TIMEOUT_EN
    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 10) ? CLOG_W : 10;

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_active;
    logic             any_hs;

    assign wd_active   = (state == S_WB_REQ) || (state == S_WB_RESP) ||
                         (state == S_RD_ADDR) || (state == S_RD_DATA);
    assign any_hs      = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    // Counter value N means N idle cycles already spent, so the limit-th stalled cycle aborts.
    assign timeout_hit = wd_active && !any_hs && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || !wd_active || any_hs || (state_next != state)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!req_ready) begin
                    if (evict_q)       state_next = S_WB_REQ;
                    else if (reload_q) state_next = S_RD_ADDR;
                    else               state_next = S_DONE;
                end
            end
            S_WB_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = S_WB_RESP;
            end
            S_WB_RESP: begin
                // The read is only issued once B is back, so aliasing addresses see the new data.
                if (b_hs) state_next = reload_q ? S_RD_ADDR : S_DONE;
            end
            S_RD_ADDR: begin
                if (ar_hs) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (r_hs) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_DONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            evict_q       <= 1'b0;
            reload_q      <= 1'b0;
            evict_addr_q  <= '0;
            addr_q        <= '0;
            axi_ext_wdata <= '0;
            axi_ext_wstrb <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            err_q         <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            state <= state_next;
            if (req_valid && req_ready) begin
                req_ready     <= 1'b0;
                evict_q       <= req_evict;
                reload_q      <= req_reload;
                evict_addr_q  <= req_evict_addr;
                addr_q        <= req_addr;
                axi_ext_wdata <= req_wdata;
                axi_ext_wstrb <= req_wstrb;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
                err_q         <= 1'b0;
            end
            if (state == S_DONE) req_ready <= 1'b1;
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs && (axi_ext_bresp != 2'b00)) err_q <= 1'b1;
            if (r_hs) begin
                rsp_rdata <= axi_ext_rdata;
                if (axi_ext_rresp != 2'b00) err_q <= 1'b1;
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_mem_port.sv
// Directed bench for cache_mem_port: table of request vectors against a scripted AXI4-Lite slave, plus reset and watchdog sequences.
module tb_cache_mem_port;

    localparam int BITS = 32;
    localparam int AB   = 28;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    logic          CLK;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic          req_evict;
    logic          req_reload;
    logic [AB-1:0] req_evict_addr;
    logic [AB-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AB+1:0] axi_ext_araddr;
    logic          axi_ext_arvalid;
    logic          axi_ext_arready;
    logic          axi_ext_rvalid;
    logic          axi_ext_rready;
    logic [31:0]   axi_ext_rdata;
    logic [1:0]    axi_ext_rresp;
    logic [AB+1:0] axi_ext_awaddr;
    logic          axi_ext_awvalid;
    logic          axi_ext_awready;
    logic          axi_ext_wvalid;
    logic          axi_ext_wready;
    logic [31:0]   axi_ext_wdata;
    logic [3:0]    axi_ext_wstrb;
    logic          axi_ext_bvalid;
    logic          axi_ext_bready;
    logic [1:0]    axi_ext_bresp;

    cache_mem_port #(.BITS(BITS), .ADDRESS_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_evict(req_evict), .req_reload(req_reload),
        .req_evict_addr(req_evict_addr), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_ext_araddr(axi_ext_araddr), .axi_ext_arvalid(axi_ext_arvalid), .axi_ext_arready(axi_ext_arready),
        .axi_ext_rvalid(axi_ext_rvalid), .axi_ext_rready(axi_ext_rready), .axi_ext_rdata(axi_ext_rdata),
        .axi_ext_rresp(axi_ext_rresp),
        .axi_ext_awaddr(axi_ext_awaddr), .axi_ext_awvalid(axi_ext_awvalid), .axi_ext_awready(axi_ext_awready),
        .axi_ext_wvalid(axi_ext_wvalid), .axi_ext_wready(axi_ext_wready), .axi_ext_wdata(axi_ext_wdata),
        .axi_ext_wstrb(axi_ext_wstrb),
        .axi_ext_bvalid(axi_ext_bvalid), .axi_ext_bready(axi_ext_bready), .axi_ext_bresp(axi_ext_bresp)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave configuration (written by the test) and per-operation statistics (written by the slave).
    int          cfg_aw_dly = 0;
    int          cfg_w_dly  = 0;
    logic        cfg_ar_block = 1'b0;
    logic        cfg_r_block  = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          clear_req = 0;

    int            n_aw, n_w, n_b, n_ar, n_r, aw_cyc, w_cyc, ar_cyc, nb_at_ar;
    int            proto_err = 0;
    logic [AB+1:0] rec_awaddr, rec_araddr;
    logic [31:0]   rec_wdata;
    logic [3:0]    rec_wstrb;

    initial begin
        int clear_seen = 0;
        int aw_cnt = 0;
        int w_cnt = 0;
        logic aw_got = 0, w_got = 0, ar_got = 0;
        logic p_awv = 0, p_awf = 0, p_wv = 0, p_wf = 0, p_arv = 0, p_arf = 0, p_bf = 0, p_rf = 0;
        logic [AB+1:0] p_awaddr = '0, p_araddr = '0;
        logic [31:0]   p_wdata = '0;
        axi_ext_awready = 0; axi_ext_wready = 0; axi_ext_arready = 0;
        axi_ext_bvalid = 0; axi_ext_bresp = 0; axi_ext_rvalid = 0; axi_ext_rdata = 0; axi_ext_rresp = 0;
        forever begin
            @(negedge CLK);
            if (clear_req != clear_seen || RST) begin
                clear_seen = clear_req;
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; nb_at_ar = -1;
                rec_awaddr = '0; rec_araddr = '0; rec_wdata = '0; rec_wstrb = '0;
                aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_bf = 0; p_rf = 0;
                axi_ext_bvalid = 0; axi_ext_rvalid = 0;
            end
            if (RST) begin
                axi_ext_awready = 0; axi_ext_wready = 0; axi_ext_arready = 0;
            end else begin
                // Valid must hold with stable payload until its handshake.
                if (p_awv && !p_awf && (!axi_ext_awvalid || axi_ext_awaddr != p_awaddr)) proto_err++;
                if (p_wv && !p_wf && (!axi_ext_wvalid || axi_ext_wdata != p_wdata)) proto_err++;
                if (p_arv && !p_arf && (!axi_ext_arvalid || axi_ext_araddr != p_araddr)) proto_err++;
                if (p_bf) axi_ext_bvalid = 0;
                if (p_rf) axi_ext_rvalid = 0;
                if (aw_got && w_got && !axi_ext_bvalid) begin
                    axi_ext_bvalid = 1; axi_ext_bresp = cfg_bresp; aw_got = 0; w_got = 0;
                end
                if (ar_got && !axi_ext_rvalid && !cfg_r_block) begin
                    axi_ext_rvalid = 1; axi_ext_rdata = cfg_rdata; axi_ext_rresp = cfg_rresp; ar_got = 0;
                end
                axi_ext_awready = axi_ext_awvalid && (aw_cnt >= cfg_aw_dly);
                axi_ext_wready  = axi_ext_wvalid && (w_cnt >= cfg_w_dly);
                axi_ext_arready = axi_ext_arvalid && !cfg_ar_block;
                aw_cnt = axi_ext_awvalid ? aw_cnt + 1 : 0;
                w_cnt  = axi_ext_wvalid ? w_cnt + 1 : 0;
                if (axi_ext_awvalid) aw_cyc++;
                if (axi_ext_wvalid)  w_cyc++;
                if (axi_ext_arvalid) ar_cyc++;
                p_awf = axi_ext_awvalid && axi_ext_awready;
                p_wf  = axi_ext_wvalid && axi_ext_wready;
                p_arf = axi_ext_arvalid && axi_ext_arready;
                p_bf  = axi_ext_bvalid && axi_ext_bready;
                p_rf  = axi_ext_rvalid && axi_ext_rready;
                if (p_awf) begin n_aw++; aw_got = 1; rec_awaddr = axi_ext_awaddr; end
                if (p_wf)  begin n_w++; w_got = 1; rec_wdata = axi_ext_wdata; rec_wstrb = axi_ext_wstrb; end
                if (p_arf) begin n_ar++; ar_got = 1; rec_araddr = axi_ext_araddr; nb_at_ar = n_b; end
                if (p_bf)  n_b++;
                if (p_rf)  n_r++;
                p_awv = axi_ext_awvalid; p_awaddr = axi_ext_awaddr;
                p_wv  = axi_ext_wvalid;  p_wdata  = axi_ext_wdata;
                p_arv = axi_ext_arvalid; p_araddr = axi_ext_araddr;
            end
        end
    end

    typedef struct {
        logic        evict;
        logic        reload;
        logic [27:0] eaddr;
        logic [27:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        logic        ar_block;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] sdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_naw;
        int          exp_nar;
        int          exp_awcyc;
        int          exp_wcyc;
    } vec_t;

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          lat;
        logic        err;
        logic [31:0] rd;
        @(negedge CLK);
        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_ar_block = v.ar_block;
        cfg_bresp = v.bresp; cfg_rresp = v.rresp; cfg_rdata = v.sdata;
        clear_req++;
        req_evict = v.evict; req_reload = v.reload; req_evict_addr = v.eaddr; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb; req_valid = 1'b1;
        check($sformatf("%s req_ready idle", tag), req_ready, 1);
        @(posedge CLK);
        lat = -1; err = 0; rd = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (c == 1) check($sformatf("%s req_ready busy", tag), req_ready, 0);
            if (rsp_valid) begin
                lat = c; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
        check($sformatf("%s latency", tag), lat, v.exp_lat);
        check($sformatf("%s rsp_err", tag), err, v.exp_err);
        check($sformatf("%s rsp_rdata", tag), rd, v.exp_rdata);
        check($sformatf("%s aw count", tag), n_aw, v.exp_naw);
        check($sformatf("%s ar count", tag), n_ar, v.exp_nar);
        if (lat < 0) begin
            do_reset();
        end else begin
            @(negedge CLK);
            check($sformatf("%s rsp_valid one cycle", tag), rsp_valid, 0);
            check($sformatf("%s req_ready after done", tag), req_ready, 1);
        end
        if (v.exp_naw > 0) begin
            check($sformatf("%s awaddr", tag), rec_awaddr, {v.eaddr, 2'b00});
            check($sformatf("%s wdata", tag), rec_wdata, v.wdata);
            check($sformatf("%s wstrb", tag), rec_wstrb, v.wstrb);
            check($sformatf("%s awvalid cycles", tag), aw_cyc, v.exp_awcyc);
            check($sformatf("%s wvalid cycles", tag), w_cyc, v.exp_wcyc);
            check($sformatf("%s b count", tag), n_b, 1);
        end
        if (v.exp_nar > 0) check($sformatf("%s araddr", tag), rec_araddr, {v.addr, 2'b00});
        if (v.exp_naw > 0 && v.exp_nar > 0) check($sformatf("%s B before AR", tag), nb_at_ar, 1);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   seen;

        // evict reload eaddr addr wdata wstrb awdly wdly arblk bresp rresp sdata | lat err rdata naw nar awcyc wcyc
        vecs[0] = '{0, 1, 28'h0, 28'h0000123, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF,
                    4, 0, 32'hDEADBEEF, 0, 1, 0, 0};
        vecs[1] = '{1, 0, 28'h0000010, 28'h0, 32'hCAFEF00D, 4'b0011, 0, 0, 0, 2'b00, 2'b00, 32'h11111111,
                    4, 0, 32'hDEADBEEF, 1, 0, 1, 1};
        vecs[2] = '{1, 1, 28'h0000020, 28'h0000020, 32'hA5A5A5A5, 4'hF, 3, 0, 0, 2'b00, 2'b00, 32'h12345678,
                    9, 0, 32'h12345678, 1, 1, 4, 1};
        vecs[3] = '{1, 1, 28'h0ABCDEF, 28'h0123456, 32'h01020304, 4'b1000, 0, 0, 0, 2'b10, 2'b00, 32'h0BADF00D,
                    6, 1, 32'h0BADF00D, 1, 1, 1, 1};
        vecs[4] = '{0, 0, 28'hFFFFFFF, 28'hFFFFFFF, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b00, 2'b00, 32'h0,
                    2, 0, 32'h0BADF00D, 0, 0, 0, 0};
        vecs[5] = '{0, 1, 28'h0, 28'hFFFFFFF, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b11, 32'h87654321,
                    4, 1, 32'h87654321, 0, 1, 0, 0};
        vecs[6] = '{1, 0, 28'h0000001, 28'h0, 32'h5A5A0000, 4'b0101, 0, 2, 0, 2'b00, 2'b00, 32'h0,
                    6, 0, 32'h87654321, 1, 0, 1, 3};
        vecs[7] = '{1, 1, 28'h0000003, 28'h0000004, 32'h0F0F0F0F, 4'hF, 1, 1, 0, 2'b00, 2'b01, 32'h13579BDF,
                    7, 1, 32'h13579BDF, 1, 1, 2, 2};

        RST = 1'b1; req_valid = 0; req_evict = 0; req_reload = 0;
        req_evict_addr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge CLK);
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset valids/readies",
              {axi_ext_arvalid, axi_ext_rready, axi_ext_awvalid, axi_ext_wvalid, axi_ext_bready}, 0);
        check("reset addresses", {axi_ext_araddr, axi_ext_awaddr}, 0);
        check("reset wdata/wstrb", {axi_ext_wdata, axi_ext_wstrb}, 0);
        RST = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while waiting for read data: everything idles, no completion appears.
        @(negedge CLK);
        cfg_r_block = 1'b1; cfg_ar_block = 1'b0; cfg_aw_dly = 0; cfg_w_dly = 0; clear_req++;
        req_evict = 0; req_reload = 1; req_addr = 28'h0000055; req_valid = 1'b1;
        @(posedge CLK);
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (axi_ext_rready) begin
                seen = c;
                break;
            end
        end
        check("rst_mid reached RD_DATA cycle", seen, 3);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid rready", axi_ext_rready, 0);
        check("rst_mid arvalid", axi_ext_arvalid, 0);
        check("rst_mid req_ready", req_ready, 1);
        check("rst_mid rsp_valid", rsp_valid, 0);
        check("rst_mid rsp_rdata", rsp_rdata, 0);
        RST = 1'b0;
        cfg_r_block = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (rsp_valid) seen++;
        end
        check("rst_mid no rsp_valid", seen, 0);
        v = '{0, 1, 28'h0, 28'h0000055, 32'h0, 4'h0, 0, 0, 0, 2'b00, 2'b00, 32'h600DCAFE,
              4, 0, 32'h600DCAFE, 0, 1, 0, 0};
        apply_vec(v, "post_rst");

        check("protocol violations", proto_err, 0);

`ifdef CACHE_MEM_PORT_TIMEOUT_EN
        // Slave never accepts AR: watchdog drops arvalid after TO cycles and flags an error.
        v = '{0, 1, 28'h0, 28'h0000077, 32'h0, 4'h0, 0, 0, 1, 2'b00, 2'b00, 32'h99999999,
              TO + 2, 1, 32'h600DCAFE, 0, 0, 0, 0};
        apply_vec(v, "timeout");
        check("timeout arvalid cycles", ar_cyc, TO);
        check("timeout arvalid low", axi_ext_arvalid, 0);
        cfg_ar_block = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_port.md
Name: cache_mem_port

Overview:
- Downstream stage of the external-memory cache. Executes the cache's line-evict (write-back) and line-reload (fill) operations on the external AXI4-Lite memory port.
- The cache issues one request at a time:
  - read (reload),
  - write (evict), or
  - evict-then-reload in one transaction.
- The block sequences the AR/R and AW/W/B channels and returns the fill data and a completion pulse to the cache state machine.

Parameters:
- BITS, 32, data word width (cache line payload).
- ADDRESS_BITS, 28, word address width of cache requests.
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with CACHE_MEM_PORT_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request strobe from cache.
- req_ready  out  1  block idle; request accepted when req_valid && req_ready.
- req_evict  in  1  perform write-back of req_evict_addr/req_wdata.
- req_reload  in  1  perform read of req_addr.
- req_evict_addr  in  ADDRESS_BITS  word address of evicted line.
- req_addr  in  ADDRESS_BITS  word address to reload.
- req_wdata  in  BITS  evicted line data.
- req_wstrb  in  4  byte strobes for the write-back.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  BITS  reload data; held until next reload completes.
- rsp_err  out  1  error flag, valid with rsp_valid.
- axi_ext_araddr  out  ADDRESS_BITS+2  byte address {req_addr,2'b00}.
- axi_ext_arvalid  out  1  read-address valid.
- axi_ext_arready  in  1  read-address ready.
- axi_ext_rvalid  in  1  read-data valid.
- axi_ext_rready  out  1  read-data ready.
- axi_ext_rdata  in  BITS  read data.
- axi_ext_rresp  in  2  read response.
- axi_ext_awaddr  out  ADDRESS_BITS+2  byte address {req_evict_addr,2'b00}.
- axi_ext_awvalid  out  1  write-address valid.
- axi_ext_awready  in  1  write-address ready.
- axi_ext_wvalid  out  1  write-data valid.
- axi_ext_wready  in  1  write-data ready.
- axi_ext_wdata  out  BITS  write data.
- axi_ext_wstrb  out  4  write strobes.
- axi_ext_bvalid  in  1  write-response valid.
- axi_ext_bready  out  1  write-response ready.
- axi_ext_bresp  in  2  write response.

Behaviour:
- Single clock CLK; reset is synchronous and active-high (RST).
- Reset values:
  - req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - All axi_ext_*valid and *ready outputs = 0.
  - Address, data and strobe outputs = 0.
  - State = IDLE.
- Request capture:
  - On accept, all req_* fields are registered.
  - req_ready drops the following cycle and stays low until the cycle after rsp_valid.
- Request with both req_evict=0 and req_reload=0: completes in DONE the next cycle, rsp_err=0, no AXI traffic.
- States:
  - IDLE:
    - evict set -> WB_REQ.
    - else reload set -> RD_ADDR.
  - WB_REQ:
    - awvalid and wvalid both asserted together.
    - Each drops independently after its own handshake; either order and the same cycle are all legal.
    - When both handshakes are done -> WB_RESP.
  - WB_RESP:
    - bready=1.
    - On bvalid: capture err |= (bresp!=0).
    - Then -> RD_ADDR if reload set, else DONE.
  - RD_ADDR:
    - arvalid=1 until arready.
    - -> RD_DATA.
  - RD_DATA:
    - rready=1.
    - On rvalid: rsp_rdata<=rdata, err |= (rresp!=0).
    - -> DONE.
  - DONE:
    - rsp_valid=1 for exactly one cycle; rsp_err = accumulated err.
    - -> IDLE. The err accumulator is cleared on the next accept.
- Evict+reload ordering: the write-back always completes (B received) before AR is issued. This guarantees read-after-write when the addresses alias.
- AXI rules:
  - Valids never drop before handshake.
  - Address and data outputs are stable while their valid is high.
  - At most one outstanding transaction per channel.
- Latency with zero-wait-state slave (ready high, response the cycle after handshake), counting accept cycle as 0:
  - reload only: rsp_valid at cycle 4.
  - evict only: cycle 4.
  - evict+reload: cycle 6.
- Response errors do not abort a combined operation; the reload still runs.
- Reset mid-operation: every valid/ready output is 0 the cycle after RST is sampled high; state returns to IDLE; no rsp_valid is generated.

Optional Feature:
- CACHE_MEM_PORT_TIMEOUT_EN defined:
  - A 10-bit+ counter runs in WB_REQ, WB_RESP, RD_ADDR and RD_DATA. It resets on every state change and on every handshake.
  - On reaching TIMEOUT_CYCLES: deassert all AXI valids and readies, go to DONE with rsp_err=1. rsp_rdata is left unchanged.
- Not defined: no counter; the block waits indefinitely. rsp_err reflects only bresp/rresp.

Test Plan:
- Reload only: req_addr=28'h0000123, slave returns rdata=32'hDEADBEEF, rresp=0 -> araddr=30'h000048C, rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid at cycle 4.
- Evict only: req_evict_addr=28'h0000010, wdata=32'hCAFEF00D, wstrb=4'b0011 -> awaddr=30'h40, wdata/wstrb match, no AR issued, rsp_valid at cycle 4.
- Evict+reload, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles, arvalid only after bvalid, one rsp_valid.
- Error: bresp=2'b10 on a combined op, rresp=0 -> reload still performed, rsp_err=1.
- RST asserted in RD_DATA with rvalid low -> next cycle rready=0, req_ready=1, no rsp_valid; a fresh reload then completes normally.
- With CACHE_MEM_PORT_TIMEOUT_EN, TIMEOUT_CYCLES=8, arready held 0 -> arvalid drops after 8 cycles, rsp_valid with rsp_err=1.
